// File: rtl/gps_emu_sequencer_pkg.sv
// Shared types and register map for the gps_emulator run-time sequencer.
// Package gps_emu_pkg: state encoding, field addresses, CTRL bit positions.
package gps_emu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] F_CODE  = 4'd0;
    localparam logic [3:0] F_DOP   = 4'd1;
    localparam logic [3:0] F_GAIN  = 4'd2;
    localparam logic [3:0] F_CASEL = 4'd3;
    localparam logic [3:0] F_CRATE = 4'd4;
    localparam logic [3:0] F_DRATE = 4'd5;

    localparam logic [3:0] G_CTRL  = 4'd0;
    localparam logic [3:0] G_SDIV  = 4'd1;
    localparam logic [3:0] G_ELEN  = 4'd2;
    localparam logic [3:0] G_NGAIN = 4'd3;

    localparam logic [3:0]  SAT_GLOBAL = 4'd15;
    localparam logic [31:0] CA_MAX     = 32'd35;

    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_COMMIT = 2;

endpackage

// File: rtl/gps_emu_strobe_gen.sv
// Sample-strobe divider and per-epoch strobe counter; both held cleared while not running.
module gps_emu_strobe_gen (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_run,
    input  logic [15:0] i_sample_div,
    input  logic [15:0] i_epoch_len,
    output logic        o_dv_in,
    output logic        o_epoch_tick
);

    logic [15:0] r_div;
    logic [15:0] r_samp;
    logic [15:0] w_len_m1;

    // epoch_len of 0 behaves as 1; >= keeps counters bounded if limits shrink mid-run
    assign w_len_m1     = (i_epoch_len == 16'd0) ? 16'd0 : i_epoch_len - 16'd1;
    assign o_dv_in      = i_run && (r_div >= i_sample_div);
    assign o_epoch_tick = o_dv_in && (r_samp >= w_len_m1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div  <= '0;
            r_samp <= '0;
        end else if (!i_run) begin
            r_div  <= '0;
            r_samp <= '0;
        end else begin
            r_div <= o_dv_in ? 16'd0 : r_div + 16'd1;
            if (o_dv_in)
                r_samp <= o_epoch_tick ? 16'd0 : r_samp + 16'd1;
        end
    end

endmodule

// File: rtl/gps_emu_sequencer.sv
// Run-time controller for the gps_emulator: config decode, shadow/active parameters, FSM, ramp.
// Optional GPS_SEQ_RAMP_EN adds per-epoch doppler/code-rate ramping (fields 4/5).
module gps_emu_sequencer
    import gps_emu_pkg::*;
#(
    parameter int NSAT      = 4,
    parameter int FLUSH_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_addr,
    input  logic [31:0]          cfg_wdata,
    output logic                 cfg_err,
    output logic                 emu_reset,
    output logic                 dv_in,
    output logic                 epoch_tick,
    output logic [31:0]          epoch_cnt,
    output logic [1:0]           state,
    output logic [32*NSAT-1:0]   code_freq,
    output logic [32*NSAT-1:0]   dop_freq,
    output logic [16*NSAT-1:0]   gain,
    output logic [6*NSAT-1:0]    ca_sel,
    output logic [15:0]          noise_gain
);

    localparam logic [4:0] NSAT_W = 5'(NSAT);
    localparam int         FW     = $clog2(FLUSH_CYC + 1);

    state_t      r_state;
    logic [FW-1:0] r_flush_cnt;
    logic        r_cfg_err;
    logic        r_commit_pend;
    logic [31:0] r_epoch_cnt;
    logic [15:0] r_sample_div;
    logic [15:0] r_epoch_len;
    logic [15:0] r_sh_ngain;
    logic [15:0] r_act_ngain;

    logic [31:0] r_sh_code  [NSAT];
    logic [31:0] r_sh_dop   [NSAT];
    logic [15:0] r_sh_gain  [NSAT];
    logic [5:0]  r_sh_ca    [NSAT];
    logic [31:0] r_act_code [NSAT];
    logic [31:0] r_act_dop  [NSAT];
    logic [15:0] r_act_gain [NSAT];
    logic [5:0]  r_act_ca   [NSAT];
`ifdef GPS_SEQ_RAMP_EN
    logic [31:0] r_sh_crate  [NSAT];
    logic [31:0] r_sh_drate  [NSAT];
    logic [31:0] r_act_crate [NSAT];
    logic [31:0] r_act_drate [NSAT];
`endif

    logic [3:0] w_sat;
    logic [3:0] w_fld;
    logic       w_err;
    logic       w_sat_we;
    logic       w_glb_we;
    logic       w_ctrl;
    logic       w_start;
    logic       w_stop;
    logic       w_commit_wr;
    logic       w_apply;
    logic       w_dv;
    logic       w_tick;

    assign w_sat = cfg_addr[7:4];
    assign w_fld = cfg_addr[3:0];

    always_comb begin
        w_err    = 1'b0;
        w_sat_we = 1'b0;
        w_glb_we = 1'b0;
        if (cfg_we) begin
            if (w_sat == SAT_GLOBAL) begin
                if (w_fld <= G_NGAIN) w_glb_we = 1'b1;
                else                  w_err    = 1'b1;
            end else if ({1'b0, w_sat} < NSAT_W) begin
                case (w_fld)
                    F_CODE, F_DOP, F_GAIN: w_sat_we = 1'b1;
                    F_CASEL: begin
                        if (cfg_wdata > CA_MAX) w_err    = 1'b1;
                        else                    w_sat_we = 1'b1;
                    end
`ifdef GPS_SEQ_RAMP_EN
                    F_CRATE, F_DRATE: w_sat_we = 1'b1;
`endif
                    default: w_err = 1'b1;
                endcase
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // stop has priority over start when both bits arrive together
    assign w_ctrl      = w_glb_we && (w_fld == G_CTRL);
    assign w_start     = w_ctrl && cfg_wdata[CTRL_START] && !cfg_wdata[CTRL_STOP] && (r_state == IDLE);
    assign w_stop      = w_ctrl && cfg_wdata[CTRL_STOP] && (r_state == RUN);
    assign w_commit_wr = w_ctrl && cfg_wdata[CTRL_COMMIT];
    assign w_apply     = r_commit_pend && ((r_state != RUN) || w_tick);

    gps_emu_strobe_gen u_strobe (
        .clk          (clk),
        .rstn         (rstn),
        .i_run        (r_state == RUN),
        .i_sample_div (r_sample_div),
        .i_epoch_len  (r_epoch_len),
        .o_dv_in      (w_dv),
        .o_epoch_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                IDLE:  if (w_start) r_state <= RUN;
                RUN: begin
                    if (w_stop) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= FW'(FLUSH_CYC - 1);
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == '0) r_state <= IDLE;
                    else                   r_flush_cnt <= r_flush_cnt - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cfg_err     <= 1'b0;
            r_commit_pend <= 1'b0;
            r_epoch_cnt   <= '0;
            r_sample_div  <= '0;
            r_epoch_len   <= 16'd1;
            r_sh_ngain    <= '0;
        end else begin
            r_cfg_err <= w_err;
            if (w_commit_wr)  r_commit_pend <= 1'b1;
            else if (w_apply) r_commit_pend <= 1'b0;
            if (w_start)     r_epoch_cnt <= '0;
            else if (w_tick) r_epoch_cnt <= r_epoch_cnt + 32'd1;
            if (w_glb_we && w_fld == G_SDIV)  r_sample_div <= cfg_wdata[15:0];
            if (w_glb_we && w_fld == G_ELEN)  r_epoch_len  <= cfg_wdata[15:0];
            if (w_glb_we && w_fld == G_NGAIN) r_sh_ngain   <= cfg_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < NSAT; s++) begin
                r_sh_code[s] <= '0;
                r_sh_dop[s]  <= '0;
                r_sh_gain[s] <= '0;
                r_sh_ca[s]   <= '0;
`ifdef GPS_SEQ_RAMP_EN
                r_sh_crate[s] <= '0;
                r_sh_drate[s] <= '0;
`endif
            end
        end else begin
            for (int s = 0; s < NSAT; s++) begin
                if (w_sat_we && (w_sat == 4'(s))) begin
                    case (w_fld)
                        F_CODE:  r_sh_code[s] <= cfg_wdata;
                        F_DOP:   r_sh_dop[s]  <= cfg_wdata;
                        F_GAIN:  r_sh_gain[s] <= cfg_wdata[15:0];
                        F_CASEL: r_sh_ca[s]   <= cfg_wdata[5:0];
`ifdef GPS_SEQ_RAMP_EN
                        F_CRATE: r_sh_crate[s] <= cfg_wdata;
                        F_DRATE: r_sh_drate[s] <= cfg_wdata;
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    // a commit landing on an epoch tick wins over that epoch's ramp step
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_act_ngain <= '0;
            for (int s = 0; s < NSAT; s++) begin
                r_act_code[s] <= '0;
                r_act_dop[s]  <= '0;
                r_act_gain[s] <= '0;
                r_act_ca[s]   <= '0;
`ifdef GPS_SEQ_RAMP_EN
                r_act_crate[s] <= '0;
                r_act_drate[s] <= '0;
`endif
            end
        end else if (w_apply) begin
            r_act_ngain <= r_sh_ngain;
            for (int s = 0; s < NSAT; s++) begin
                r_act_code[s] <= r_sh_code[s];
                r_act_dop[s]  <= r_sh_dop[s];
                r_act_gain[s] <= r_sh_gain[s];
                r_act_ca[s]   <= r_sh_ca[s];
`ifdef GPS_SEQ_RAMP_EN
                r_act_crate[s] <= r_sh_crate[s];
                r_act_drate[s] <= r_sh_drate[s];
`endif
            end
`ifdef GPS_SEQ_RAMP_EN
        end else if (w_tick) begin
            for (int s = 0; s < NSAT; s++) begin
                r_act_code[s] <= r_act_code[s] + r_act_crate[s];
                r_act_dop[s]  <= r_act_dop[s] + r_act_drate[s];
            end
`endif
        end
    end

    for (genvar s = 0; s < NSAT; s++) begin : g_out
        assign code_freq[32*s +: 32] = r_act_code[s];
        assign dop_freq[32*s +: 32]  = r_act_dop[s];
        assign gain[16*s +: 16]      = r_act_gain[s];
        assign ca_sel[6*s +: 6]      = r_act_ca[s];
    end

    assign cfg_err    = r_cfg_err;
    assign emu_reset  = (r_state != RUN);
    assign dv_in      = w_dv;
    assign epoch_tick = w_tick;
    assign epoch_cnt  = r_epoch_cnt;
    assign state      = r_state;
    assign noise_gain = r_act_ngain;

endmodule

// File: tb/tb_gps_emu_sequencer.sv
// Directed self-checking bench for gps_emu_sequencer; ramp checks run when GPS_SEQ_RAMP_EN is defined.
module tb_gps_emu_sequencer;

    localparam int NSAT = 4;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                cfg_we = 1'b0;
    logic [7:0]          cfg_addr = '0;
    logic [31:0]         cfg_wdata = '0;
    logic                cfg_err;
    logic                emu_reset;
    logic                dv_in;
    logic                epoch_tick;
    logic [31:0]         epoch_cnt;
    logic [1:0]          state;
    logic [32*NSAT-1:0]  code_freq;
    logic [32*NSAT-1:0]  dop_freq;
    logic [16*NSAT-1:0]  gain;
    logic [6*NSAT-1:0]   ca_sel;
    logic [15:0]         noise_gain;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gps_emu_sequencer #(.NSAT(NSAT), .FLUSH_CYC(64)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_err    (cfg_err),
        .emu_reset  (emu_reset),
        .dv_in      (dv_in),
        .epoch_tick (epoch_tick),
        .epoch_cnt  (epoch_cnt),
        .state      (state),
        .code_freq  (code_freq),
        .dop_freq   (dop_freq),
        .gain       (gain),
        .ca_sel     (ca_sel),
        .noise_gain (noise_gain)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; the write is sampled on the following posedge
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (state !== 2'd0 && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk("flush_to_idle", state, 2'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_emu_reset", emu_reset, 1'b1);
        chk("rst_dv_in", dv_in, 1'b0);
        chk("rst_state", state, 2'd0);
        chk("rst_code", code_freq, '0);
        chk("rst_dop", dop_freq, '0);
        chk("rst_gain_ca_ng", {gain, ca_sel, noise_gain}, '0);
        chk("rst_epoch", {epoch_cnt, epoch_tick, cfg_err}, '0);
        rstn = 1'b1;
        @(negedge clk);

        // rejected writes and IDLE commit timing
        wr(8'h03, 32'd36);
        chk("err_ca36", cfg_err, 1'b1);
        wr(8'h73, 32'd5);
        chk("err_sat7", cfg_err, 1'b1);
        wr(8'h06, 32'd1);
        chk("err_field6", cfg_err, 1'b1);
        wr(8'hF4, 32'd1);
        chk("err_gfield4", cfg_err, 1'b1);
        wr(8'h03, 32'd35);
        chk("ok_ca35", cfg_err, 1'b0);
        wr(8'h05, 32'd0);
`ifdef GPS_SEQ_RAMP_EN
        chk("rate_field", cfg_err, 1'b0);
`else
        chk("rate_field", cfg_err, 1'b1);
`endif
        wr(8'hF3, 32'h0000_ABCD);
        wr(8'hF0, 32'd4);
        chk("idle_commit_pre", ca_sel[5:0], 6'd0);
        @(negedge clk);
        chk("idle_commit_ca", ca_sel[5:0], 6'd35);
        chk("idle_commit_ng", noise_gain, 16'hABCD);
        wr(8'hF0, 32'd3);
        chk("start_stop_state", state, 2'd0);
        chk("start_stop_rst", emu_reset, 1'b1);

        // cadence: sample_div=3, epoch_len=4
        wr(8'hF1, 32'd3);
        wr(8'hF2, 32'd4);
        wr(8'hF0, 32'd1);
        chk("run_emu_reset", emu_reset, 1'b0);
        for (int c = 1; c <= 48; c++) begin
            chk($sformatf("dv_c%0d", c), dv_in, (c % 4) == 0);
            chk($sformatf("tick_c%0d", c), epoch_tick, (c % 16) == 0);
            chk($sformatf("state_c%0d", c), state, 2'd1);
            @(negedge clk);
        end
        chk("epoch_cnt_48", epoch_cnt, 32'd3);

        // RUN commit waits for the next tick (cycle 64)
        wr(8'h01, 32'd1000);
        wr(8'hF0, 32'd4);
        for (int c = 51; c <= 64; c++) begin
            chk($sformatf("run_commit_hold_c%0d", c), dop_freq[31:0], 32'd0);
            @(negedge clk);
        end
        chk("run_commit_dop", dop_freq[31:0], 32'd1000);

        // stop on the cycle before a strobe
        repeat (2) @(negedge clk);
        wr(8'hF0, 32'd2);
        chk("stop_dv", dv_in, 1'b0);
        chk("stop_state", state, 2'd2);
        chk("stop_emu_reset", emu_reset, 1'b1);
        chk("stop_epoch_hold", epoch_cnt, 32'd4);
        repeat (63) @(negedge clk);
        chk("flush_last", state, 2'd2);
        @(negedge clk);
        chk("flush_done", state, 2'd0);
        chk("flush_epoch_hold", epoch_cnt, 32'd4);

        // sample_div=0 and epoch_len=0: strobe and tick every cycle
        wr(8'hF1, 32'd0);
        wr(8'hF2, 32'd0);
        wr(8'hF0, 32'd1);
        chk("div0_dv1", dv_in, 1'b1);
        chk("len0_tick1", epoch_tick, 1'b1);
        chk("div0_epoch0", epoch_cnt, 32'd0);
        @(negedge clk);
        chk("div0_dv2", dv_in, 1'b1);
        chk("div0_epoch1", epoch_cnt, 32'd1);
        @(negedge clk);
        chk("div0_epoch2", epoch_cnt, 32'd2);
        chk("no_ramp_dop", dop_freq[31:0], 32'd1000);
        wr(8'hF0, 32'd2);
        wait_idle();

`ifdef GPS_SEQ_RAMP_EN
        wr(8'h01, 32'd2);
        wr(8'h05, 32'hFFFF_FFFB);
        wr(8'hF0, 32'd4);
        @(negedge clk);
        chk("ramp_init", dop_freq[31:0], 32'd2);
        wr(8'hF0, 32'd1);
        chk("ramp_c1", dop_freq[31:0], 32'd2);
        repeat (3) @(negedge clk);
        chk("ramp_3ep", dop_freq[31:0], 32'hFFFF_FFF3);
        wr(8'h01, 32'd100);
        wr(8'hF0, 32'd4);
        chk("ramp_pre_commit", dop_freq[31:0], 32'hFFFF_FFE9);
        @(negedge clk);
        chk("commit_on_tick", dop_freq[31:0], 32'd100);
        @(negedge clk);
        chk("ramp_after_commit", dop_freq[31:0], 32'd95);
        wr(8'hF0, 32'd2);
        wait_idle();
`endif

        // async reset mid-RUN
        wr(8'hF1, 32'd3);
        wr(8'hF2, 32'd4);
        wr(8'hF0, 32'd1);
        repeat (19) @(negedge clk);
        chk("pre_rst_epoch", epoch_cnt, 32'd1);
        chk("pre_rst_state", state, 2'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_emu_reset", emu_reset, 1'b1);
        chk("arst_state", state, 2'd0);
        chk("arst_dv", dv_in, 1'b0);
        chk("arst_epoch", epoch_cnt, 32'd0);
        chk("arst_active", {dop_freq, ca_sel, noise_gain}, '0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
